// File: rtl/keypad_pkg.sv
// Shared types and sizing helpers for the keypad encoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } key_state_e;

    // Width of a binary key index; never narrower than one bit.
    function automatic int code_width(input int num_keys);
        return (num_keys > 1) ? $clog2(num_keys) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a vector of independent asynchronous lines.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_data,
    output logic [WIDTH-1:0] sync_data
);

    logic [WIDTH-1:0] meta;

    // NOTE: reset is synchronous, so it is sampled inside the clocked block and nowhere else.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta      <= '0;
            sync_data <= '0;
        end else begin
            meta      <= async_data;
            sync_data <= meta;
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// Debounced one-key-at-a-time keypad encoder with a valid/ready event output,
// held and multi-key status, and a sticky overrun flag.
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int  NUM_KEYS        = 10,
    parameter int  DEBOUNCE_CYCLES = 4,
    localparam int CODE_W          = code_width(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_i,
    output logic [CODE_W-1:0]   code_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                held_o,
    output logic                multi_o,
    output logic                overrun_o,
    input  logic                clear_i
);

    localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int               LAST_COUNT = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(LAST_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    function automatic int unsigned popcount(input logic [NUM_KEYS-1:0] vec);
        int unsigned n;
        n = 0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (vec[k]) n++;
        end
        return n;
    endfunction

    function automatic logic [CODE_W-1:0] onehot_to_bin(input logic [NUM_KEYS-1:0] vec);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (vec[k]) idx |= CODE_W'(k);
        end
        return idx;
    endfunction

    logic [NUM_KEYS-1:0] ksync;
    logic [NUM_KEYS-1:0] captured, captured_next;
    logic [CNT_W-1:0]    count, count_next, count_inc;
    key_state_e          state, state_next;
    logic                one_hot, all_zero, last_sample;
    logic                fire, drop;
    logic [CODE_W-1:0]   event_code;

    sync_2ff #(.WIDTH(NUM_KEYS)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .async_data (key_i),
        .sync_data  (ksync)
    );

    assign one_hot   = (popcount(ksync) == 1);
    assign all_zero  = (ksync == '0);
    assign multi_o   = (popcount(ksync) > 1);
    assign held_o    = (state == ST_PRESSED) || (state == ST_RELEASE);
    assign count_inc = (count == CNT_MAX) ? count : count + 1'b1;
    // The entry sample counts as the first stable one, so the last is at count D-2.
    assign last_sample = (count >= CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            captured <= '0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            captured <= captured_next;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path leaves a latch.
    always_comb begin
        state_next    = state;
        count_next    = count;
        captured_next = captured;
        fire          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (one_hot) begin
                    captured_next = ksync;
                    count_next    = '0;
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_next = ST_PRESSED;
                        fire       = 1'b1;
                    end else begin
                        state_next = ST_DEBOUNCE;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (ksync != captured) begin
                    state_next = ST_IDLE;
                end else if (last_sample) begin
                    state_next = ST_PRESSED;
                    fire       = 1'b1;
                end else begin
                    count_next = count_inc;
                end
            end
            ST_PRESSED: begin
                if (all_zero) begin
                    count_next = '0;
                    state_next = (DEBOUNCE_CYCLES == 1) ? ST_IDLE : ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!all_zero) begin
                    state_next = ST_PRESSED;
                end else if (last_sample) begin
                    state_next = ST_IDLE;
                end else begin
                    count_next = count_inc;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign event_code = onehot_to_bin(captured_next);
    assign drop       = fire && valid_o && !ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o   <= 1'b0;
            code_o    <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (fire && !drop) begin
                valid_o <= 1'b1;
                code_o  <= event_code;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            if (drop) begin
                overrun_o <= 1'b1;
            end else if (clear_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: directed scenarios plus a randomized
// run compared every cycle against a run-length based reference model.
module tb_keypad_encoder;

    localparam int NK  = 10;
    localparam int DEB = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_i;
    logic [CW-1:0] code_o;
    logic          valid_o;
    logic          ready_i;
    logic          held_o;
    logic          multi_o;
    logic          overrun_o;
    logic          clear_i;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    keypad_encoder #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_i     (key_i),
        .code_o    (code_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .held_o    (held_o),
        .multi_o   (multi_o),
        .overrun_o (overrun_o),
        .clear_i   (clear_i)
    );

    // Reference model: a press is accepted once the synchronized value has been
    // the same single key for DEB samples while nothing is held; a hold ends
    // after DEB consecutive all-zero samples.
    logic [NK-1:0] m_q1, m_q2, m_prev;
    int            m_run;
    bit            m_held, m_valid, m_ovr;
    logic [CW-1:0] m_code;

    task automatic model_step();
        logic [NK-1:0] s;
        bit            fire, drop;
        logic [CW-1:0] nc;
        if (rst) begin
            m_q1 = '0; m_q2 = '0; m_prev = '0; m_run = 0;
            m_held = 0; m_valid = 0; m_ovr = 0; m_code = '0;
            return;
        end
        s = m_q2;
        if (s == m_prev) begin
            if (m_run < 1000000) m_run++;
        end else begin
            m_run = 1;
        end
        m_prev = s;
        fire = 0;
        nc = '0;
        if (!m_held && $countones(s) == 1 && m_run == DEB) begin
            fire = 1;
            m_held = 1;
            for (int k = 0; k < NK; k++) if (s[k]) nc = CW'(k);
        end else if (m_held && s == '0 && m_run >= DEB) begin
            m_held = 0;
        end
        drop = fire && m_valid && !ready_i;
        if (drop) m_ovr = 1;
        else if (clear_i) m_ovr = 0;
        if (fire && !drop) begin
            m_valid = 1;
            m_code = nc;
        end else if (m_valid && ready_i) begin
            m_valid = 0;
        end
        m_q2 = m_q1;
        m_q1 = key_i;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick_n(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        key_i = NK'(3); ready_i = 1'b0; clear_i = 1'b0;
        apply_reset();
        n_cmp++;
        if ({valid_o, code_o, held_o, multi_o, overrun_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b c=%0d h=%b m=%b o=%b, want all 0",
                     valid_o, code_o, held_o, multi_o, overrun_o);
        end
        tick();
        n_cmp++;
        if (multi_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_sync_cleared: multi_o=%b want 0", multi_o);
        end
        tick();
        n_cmp++;
        if (multi_o !== 1'b1) begin
            n_bad++; $display("FAIL reset_multi_after_sync: multi_o=%b want 1", multi_o);
        end
        key_i = '0;
        tick_n(4);
    endtask

    task automatic test_single_press();
        apply_reset();
        ready_i = 1'b1;
        key_i = NK'(1) << 7;
        for (int c = 1; c <= 12; c++) begin
            tick();
            n_cmp++;
            if (valid_o !== (c == 6) || held_o !== (c >= 6)) begin
                n_bad++;
                $display("FAIL press_timing cycle %0d: valid=%b held=%b want valid=%b held=%b",
                         c, valid_o, held_o, c == 6, c >= 6);
            end
            if (c == 6) begin
                n_cmp++;
                if (code_o !== 4'd7) begin
                    n_bad++; $display("FAIL press_code: code=%0d want 7", code_o);
                end
            end
        end
        key_i = '0;
        for (int r = 1; r <= 8; r++) begin
            tick();
            n_cmp++;
            if (held_o !== (r < 6) || valid_o !== 1'b0) begin
                n_bad++;
                $display("FAIL release_timing cycle %0d: held=%b valid=%b want held=%b valid=0",
                         r, held_o, valid_o, r < 6);
            end
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        ready_i = 1'b1;
        key_i = NK'(1) << 3;
        tick_n(3);
        key_i = '0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            n_cmp++;
            if (valid_o !== 1'b0 || held_o !== 1'b0) begin
                n_bad++;
                $display("FAIL glitch_ignored cycle %0d: valid=%b held=%b want 0 0", t, valid_o, held_o);
            end
        end
        key_i = NK'(1) << 4;
        for (int c = 1; c <= 8; c++) begin
            tick();
            n_cmp++;
            if (valid_o !== (c == 6) || (c == 6 && code_o !== 4'd4)) begin
                n_bad++;
                $display("FAIL glitch_then_press cycle %0d: valid=%b code=%0d want valid=%b code=4",
                         c, valid_o, code_o, c == 6);
            end
        end
        key_i = '0;
        tick_n(8);
    endtask

    task automatic test_multi();
        apply_reset();
        ready_i = 1'b0;
        key_i = (NK'(1) << 2) | (NK'(1) << 5);
        for (int c = 1; c <= 20; c++) begin
            tick();
            n_cmp++;
            if (multi_o !== (c >= 2) || valid_o !== 1'b0) begin
                n_bad++;
                $display("FAIL multi_hold cycle %0d: multi=%b valid=%b want multi=%b valid=0",
                         c, multi_o, valid_o, c >= 2);
            end
        end
        key_i = NK'(1) << 2;
        for (int t = 1; t <= 8; t++) begin
            tick();
            n_cmp++;
            if (valid_o !== (t >= 6) || multi_o !== (t < 2) || (t >= 6 && code_o !== 4'd2)) begin
                n_bad++;
                $display("FAIL multi_release cycle %0d: valid=%b multi=%b code=%0d want valid=%b multi=%b code=2",
                         t, valid_o, multi_o, code_o, t >= 6, t < 2);
            end
        end
        ready_i = 1'b1;
        tick();
        n_cmp++;
        if (valid_o !== 1'b0) begin
            n_bad++; $display("FAIL multi_accept: valid=%b want 0", valid_o);
        end
        ready_i = 1'b0;
        key_i = '0;
        tick_n(8);
    endtask

    task automatic test_overrun();
        apply_reset();
        ready_i = 1'b0;
        key_i = NK'(1) << 1;
        tick_n(8);
        n_cmp++;
        if (valid_o !== 1'b1 || code_o !== 4'd1 || overrun_o !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_first: valid=%b code=%0d ovr=%b want 1 1 0", valid_o, code_o, overrun_o);
        end
        key_i = '0;
        tick_n(8);
        key_i = NK'(1) << 9;
        for (int t = 1; t <= 8; t++) begin
            tick();
            n_cmp++;
            if (overrun_o !== (t >= 6) || valid_o !== 1'b1 || code_o !== 4'd1) begin
                n_bad++;
                $display("FAIL overrun_drop cycle %0d: ovr=%b valid=%b code=%0d want ovr=%b valid=1 code=1",
                         t, overrun_o, valid_o, code_o, t >= 6);
            end
        end
        key_i = '0;
        tick_n(8);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        n_cmp++;
        if (valid_o !== 1'b0 || overrun_o !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_accept: valid=%b ovr=%b want 0 1", valid_o, overrun_o);
        end
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        n_cmp++;
        if (overrun_o !== 1'b0) begin
            n_bad++; $display("FAIL overrun_clear: ovr=%b want 0", overrun_o);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        ready_i = 1'b0;
        key_i = NK'(1) << 4;
        tick_n(8);
        key_i = '0;
        tick_n(8);
        key_i = NK'(1) << 6;
        for (int t = 1; t <= 6; t++) begin
            ready_i = (t == 6);
            tick();
        end
        ready_i = 1'b0;
        n_cmp++;
        if (valid_o !== 1'b1 || code_o !== 4'd6 || overrun_o !== 1'b0) begin
            n_bad++;
            $display("FAIL accept_and_load: valid=%b code=%0d ovr=%b want 1 6 0", valid_o, code_o, overrun_o);
        end
        key_i = '0;
        tick_n(8);
        key_i = NK'(1) << 8;
        for (int t = 1; t <= 6; t++) begin
            clear_i = (t == 6);
            tick();
        end
        clear_i = 1'b0;
        n_cmp++;
        if (overrun_o !== 1'b1 || valid_o !== 1'b1 || code_o !== 4'd6) begin
            n_bad++;
            $display("FAIL set_beats_clear: ovr=%b valid=%b code=%0d want 1 1 6", overrun_o, valid_o, code_o);
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        key_i = '0;
        tick_n(8);
    endtask

    task automatic test_bounce_reset();
        int events;
        apply_reset();
        ready_i = 1'b1;
        events = 0;
        for (int c = 0; c < 26; c++) begin
            key_i = (c < 10 || c == 12 || c == 15) ? NK'(1) : '0;
            tick();
            if (valid_o === 1'b1) begin
                events++;
                n_cmp++;
                if (code_o !== 4'd0) begin
                    n_bad++; $display("FAIL bounce_code: code=%0d want 0", code_o);
                end
            end
        end
        n_cmp++;
        if (events != 1 || held_o !== 1'b0) begin
            n_bad++;
            $display("FAIL bounce_single_event: events=%0d held=%b want 1 0", events, held_o);
        end
        key_i = NK'(1) << 5;
        tick_n(4);
        rst = 1'b1;
        for (int t = 1; t <= 2; t++) begin
            tick();
            n_cmp++;
            if ({valid_o, code_o, held_o, multi_o, overrun_o} !== '0) begin
                n_bad++;
                $display("FAIL reset_mid_debounce cycle %0d: v=%b c=%0d h=%b m=%b o=%b want all 0",
                         t, valid_o, code_o, held_o, multi_o, overrun_o);
            end
        end
        rst = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            n_cmp++;
            if (valid_o !== (t == 6) || (t == 6 && code_o !== 4'd5)) begin
                n_bad++;
                $display("FAIL held_through_reset cycle %0d: valid=%b code=%0d want valid=%b code=5",
                         t, valid_o, code_o, t == 6);
            end
        end
        key_i = '0;
        tick_n(8);
    endtask

    task automatic test_random();
        int            seg_left;
        int            kind;
        bit            prev_onehot;
        logic [NK-1:0] val;
        apply_reset();
        seg_left = 0;
        prev_onehot = 0;
        for (int c = 0; c < 1500; c++) begin
            if (seg_left == 0) begin
                kind = int'($urandom_range(0, 9));
                seg_left = int'($urandom_range(1, 9));
                if (kind < 4) begin
                    val = '0;
                end else if (kind < 8) begin
                    val = NK'(1) << $urandom_range(0, NK - 1);
                    if (prev_onehot && val != key_i) begin
                        val = '0;
                        seg_left = 1;
                    end
                end else begin
                    val = (NK'(1) << $urandom_range(0, 4)) | (NK'(1) << $urandom_range(5, 9))
                        | (NK'($urandom) & NK'($urandom));
                end
                prev_onehot = ($countones(val) == 1);
                key_i = val;
            end
            seg_left--;
            ready_i = 1'($urandom_range(0, 1));
            clear_i = ($urandom_range(0, 7) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            tick();
            n_cmp++;
            if (valid_o !== m_valid || held_o !== m_held || overrun_o !== m_ovr
                || multi_o !== ($countones(m_q2) > 1) || (m_valid && code_o !== m_code)) begin
                n_bad++;
                $display("FAIL random cycle %0d: got v=%b c=%0d h=%b m=%b o=%b want v=%b c=%0d h=%b m=%b o=%b",
                         c, valid_o, code_o, held_o, multi_o, overrun_o,
                         m_valid, m_code, m_held, $countones(m_q2) > 1, m_ovr);
            end
        end
        rst = 1'b0;
        clear_i = 1'b0;
        key_i = '0;
        ready_i = 1'b1;
        tick_n(8);
    endtask

    initial begin
        rst = 1'b1; key_i = '0; ready_i = 1'b0; clear_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_press();
        test_glitch();
        test_multi();
        test_overrun();
        test_back_to_back();
        test_bounce_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 Parameter NUM_KEYS, default 10, number of one-per-key active-high inputs (2..64).
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized samples required to accept a press or release (1..2^20).
REQ-003 Derived constant CODE_W = max(1, clog2(NUM_KEYS)); not overridable.
REQ-004 clk  input  1  single clock; all state on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 key_i  input  NUM_KEYS  raw asynchronous key lines; bit k high = key k pressed.
REQ-007 code_o  output  CODE_W  binary index of the accepted key; valid only while valid_o is high.
REQ-008 valid_o  output  1  key event pending; held until accepted.
REQ-009 ready_i  input  1  consumer accepts the event when valid_o and ready_i are both high.
REQ-010 held_o  output  1  a debounced key is currently held (state PRESSED or RELEASE).
REQ-011 multi_o  output  1  high while the synchronized vector has more than one bit set.
REQ-012 overrun_o  output  1  sticky; an event was dropped because the previous one was not accepted.
REQ-013 clear_i  input  1  clears overrun_o on the next edge.

Function
REQ-014 key_i SHALL pass through a 2-flop synchronizer; ksync denotes its output.
REQ-015 FSM states SHALL be IDLE, DEBOUNCE, PRESSED and RELEASE.
REQ-016 IDLE: if ksync is one-hot, capture it, clear the counter, and go to DEBOUNCE; zero or multi-hot stays in IDLE.
REQ-017 DEBOUNCE: if ksync equals the captured vector, increment the counter; on the DEBOUNCE_CYCLES-th consecutive match, go to PRESSED and raise the event.
REQ-018 DEBOUNCE: any mismatch, including a multi-hot value, SHALL return the FSM to IDLE with no event.
REQ-019 PRESSED: when ksync is all-zero, clear the counter and go to RELEASE; any other change is ignored and produces no new event.
REQ-020 RELEASE: count consecutive all-zero samples; after DEBOUNCE_CYCLES of them go to IDLE; any nonzero sample returns to PRESSED.
REQ-021 Event code SHALL be the index of the single set bit in the captured vector.
REQ-022 Latency from key_i becoming stable one-hot to valid_o high SHALL be exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-023 valid_o and code_o SHALL be stable from assertion until the cycle valid_o and ready_i are both high; valid_o falls on the next edge unless a new event loads on that same edge.
REQ-024 New event while valid_o is high and ready_i is low: keep the old code, drop the new one, set overrun_o.
REQ-025 New event on the same edge as acceptance: load the new code, keep valid_o high, leave overrun_o unchanged.
REQ-026 Simultaneous clear_i and overrun condition: set wins, so overrun_o stays 1.
REQ-027 multi_o SHALL be combinational from ksync (popcount > 1), independent of FSM state.
REQ-028 The debounce counter SHALL saturate and never wrap.

Reset
REQ-029 On rst: FSM = IDLE; counter, captured vector and synchronizer = 0; code_o = 0, valid_o = 0, overrun_o = 0, held_o = 0.
REQ-030 rst asserted mid-DEBOUNCE, PRESSED or RELEASE SHALL discard any in-progress or pending event, with no output glitch to valid_o = 1.
REQ-031 After rst deasserts, a key already held SHALL be treated as a new press (full 2 + DEBOUNCE_CYCLES latency).

Structure
REQ-032 Package keypad_pkg SHALL hold the FSM state enum and a clog2-based CODE_W helper function.
REQ-033 The synchronizer SHALL be a separate sub-module, sync_2ff, parametrised by width.
REQ-034 The one-hot-to-binary encoder and the popcount SHALL be functions inside keypad_encoder; no vendor gate primitives.

Verification (NUM_KEYS = 10, DEBOUNCE_CYCLES = 4)
REQ-035 key_i = 10'b0010000000 held from cycle 0, ready_i = 1 -> valid_o high at cycle 6 only, code_o = 7, held_o = 1 until release completes.
REQ-036 key_i bit 3 pulses high for 3 cycles then low -> no valid_o, FSM returns to IDLE, held_o never 1.
REQ-037 key_i = bits 2 and 5 together for 20 cycles -> multi_o = 1 from cycle 2, no event; then release bit 5 -> event code 2 at 2 + 4 cycles later.
REQ-038 ready_i = 0; press/release key 1, then key 9 -> code_o stays 1, valid_o stays high, overrun_o = 1; raise ready_i -> valid_o drops; pulse clear_i -> overrun_o = 0.
REQ-039 Press key 0 with 2-cycle bounce gaps during release -> exactly one event, code 0; assert rst during a second key's DEBOUNCE -> no event, all outputs 0.
